cop_ctrl: RTL and testbench
===========================

COP_CTRL -- requirements
Module: cop_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 1023, max WAIT cycles before abort (2..65535).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_we  input  1  CPU register write strobe.
REQ-005 cpu_addr  input  2  register select: 0 OPERANDS, 1 CTRL, 2 STATUS, 3 RESULT.
REQ-006 cpu_wdata  input  32  write data.
REQ-007 cpu_rdata  output  32  read data, combinational from cpu_addr.
REQ-008 cop_start  output  1  one-cycle launch pulse to coprocessor.
REQ-009 cop_operand  output  32  {A[15:0], B[15:0]} to coprocessor, held stable from LAUNCH through end of WAIT.
REQ-010 cop_op  output  1  0 = GCD, 1 = LCM; held with cop_operand.
REQ-011 cop_done  input  1  coprocessor completion; valid in WAIT only.
REQ-012 cop_result  input  32  coprocessor answer, valid when cop_done=1.
REQ-013 irq  output  1  level interrupt = irq_en & (done | timeout).

Function
REQ-014 Registers: OPERANDS (RW, A=[31:16], B=[15:0]); CTRL write-only bits: 0 go, 1 op, 2 irq_en, 3 clr; STATUS (RO): 0 busy, 1 done, 2 timeout, 3 op; RESULT (RO); writes to RO addresses ignored; CTRL reads as {29'b0, irq_en, op, 1'b0}.
REQ-015 FSM states IDLE, LAUNCH, WAIT; busy = (state != IDLE).
REQ-016 IDLE + CTRL write with go=1: latch op, clear done/timeout; if A==0 or B==0 -> bypass, else -> LAUNCH.
REQ-017 Bypass: stay IDLE, no cop_start; RESULT = A|B (GCD) or 0 (LCM), zero-extended; done=1 on next cycle.
REQ-018 LAUNCH: cop_start=1 for exactly this cycle; clear timeout counter; -> WAIT unconditionally.
REQ-019 WAIT: counter increments each cycle; cop_done=1 -> RESULT<=cop_result, done<=1, -> IDLE.
REQ-020 WAIT with counter reaching TIMEOUT and cop_done=0 -> RESULT<=32'hFFFF_FFFF, timeout<=1, -> IDLE.
REQ-021 cop_done and timeout in same cycle: done wins, timeout stays 0.
REQ-022 cop_done outside WAIT ignored; cop_result ignored unless captured per REQ-019.
REQ-023 Latency: go write at edge N -> cop_start high cycle N+1 -> WAIT from N+2; cop_done at cycle K -> STATUS.done=1 and busy=0 from K+1.
REQ-024 While busy: writes to OPERANDS and go are ignored; irq_en and clr still take effect.
REQ-025 clr=1: clears done and timeout next cycle; clr and go in same write in IDLE: go takes effect (flags end cleared, new operation starts).
REQ-026 irq_en bit updates on every CTRL write; op bit updates only when go is accepted.
REQ-027 done and timeout are sticky until clr or accepted go.

Reset
REQ-028 reset=1 at any edge (including mid-WAIT): state IDLE, OPERANDS=0, RESULT=0, op=0, irq_en=0, done=0, timeout=0, counter=0.
REQ-029 Outputs after reset: cop_start=0, cop_operand=0, cop_op=0, irq=0; in-flight cop_done after reset ignored.

Verification
REQ-030 OPERANDS=0x000C_0012, go op=0, model done 5 cycles after start with 6 -> one cop_start pulse, RESULT=6, STATUS=0x2.
REQ-031 OPERANDS=0x0004_0006, go op=1, irq_en=1, model returns 12 -> RESULT=12, STATUS=0xA, irq=1 until clr, then irq=0.
REQ-032 OPERANDS=0x0000_0007, go op=0 -> no cop_start, RESULT=7, done=1 next cycle; same with op=1 -> RESULT=0.
REQ-033 TIMEOUT=8, model never asserts done -> RESULT=0xFFFFFFFF, STATUS.timeout=1 after 8 WAIT cycles; variant with done on cycle 8 -> done wins.
REQ-034 During WAIT write OPERANDS=0x0001_0001 and go -> ignored, cop_operand unchanged, single cop_start pulse total.
REQ-035 reset asserted mid-WAIT, then late cop_done -> all registers zero, state IDLE, RESULT stays 0.

Source files
------------

// File: rtl/cop_ctrl.sv
// CPU-facing controller for a GCD/LCM coprocessor: register file, launch/wait
// sequencing with timeout, zero-operand bypass and a level interrupt.
module cop_ctrl #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cop_start,
  output logic [31:0] cop_operand,
  output logic        cop_op,
  input  logic        cop_done,
  input  logic [31:0] cop_result,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0]  ADDR_OPERANDS = 2'd0;
  localparam logic [1:0]  ADDR_CTRL     = 2'd1;
  localparam logic [1:0]  ADDR_STATUS   = 2'd2;
  localparam logic [15:0] CNT_LAST      = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] operands_q, operands_d;
  logic [31:0] result_q, result_d;
  logic        op_q, op_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [15:0] cnt_q, cnt_d;

  logic ctrl_wr, go, clr, busy, zero_operand;

  always_comb begin
    ctrl_wr      = cpu_we && (cpu_addr == ADDR_CTRL);
    go           = ctrl_wr && cpu_wdata[0];
    clr          = ctrl_wr && cpu_wdata[3];
    busy         = (state_q != ST_IDLE);
    zero_operand = (operands_q[31:16] == 16'd0) || (operands_q[15:0] == 16'd0);
  end

  always_comb begin
    state_d    = state_q;
    operands_d = operands_q;
    result_d   = result_q;
    op_d       = op_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;

    if (ctrl_wr) irq_en_d = cpu_wdata[2];
    if (clr) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end

    // Completion events below are assigned after clr so they take priority.
    case (state_q)
      ST_IDLE: begin
        if (cpu_we && (cpu_addr == ADDR_OPERANDS)) operands_d = cpu_wdata;
        if (go) begin
          op_d      = cpu_wdata[1];
          done_d    = 1'b0;
          timeout_d = 1'b0;
          if (zero_operand) begin
            result_d = cpu_wdata[1] ? 32'd0 : {16'd0, operands_q[31:16] | operands_q[15:0]};
            done_d   = 1'b1;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        cnt_d   = 16'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cop_done) begin
          result_d = cop_result;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          result_d  = 32'hFFFF_FFFF;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      operands_q <= 32'd0;
      result_q   <= 32'd0;
      op_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      operands_q <= operands_d;
      result_q   <= result_d;
      op_q       <= op_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    cop_start   = (state_q == ST_LAUNCH);
    cop_operand = operands_q;
    cop_op      = op_q;
    irq         = irq_en_q & (done_q | timeout_q);
    case (cpu_addr)
      ADDR_OPERANDS: cpu_rdata = operands_q;
      ADDR_CTRL:     cpu_rdata = {29'd0, irq_en_q, op_q, 1'b0};
      ADDR_STATUS:   cpu_rdata = {28'd0, op_q, timeout_q, done_q, busy};
      default:       cpu_rdata = result_q;
    endcase
  end

endmodule

// File: tb/tb_cop_ctrl.sv
// Randomized transaction-level bench for cop_ctrl; the coprocessor answer is
// computed arithmetically and completion timing follows the register-level rules.
module tb_cop_ctrl;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [1:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata, cop_operand, cop_result;
  logic        cop_start, cop_op, cop_done, irq;

  int n_vec = 0;
  int n_err = 0;
  int starts = 0;

  logic [31:0] m_operands, m_result;
  logic        m_op, m_irq_en, m_done, m_tmo;

  cop_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cop_start(cop_start),
    .cop_operand(cop_operand), .cop_op(cop_op), .cop_done(cop_done),
    .cop_result(cop_result), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cop_start === 1'b1) starts++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cpu_addr = a;
    #1;
    d = cpu_rdata;
  endtask

  function automatic logic [31:0] gcd(input int unsigned a, input int unsigned b);
    int unsigned x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  function automatic logic [31:0] lcm(input int unsigned a, input int unsigned b);
    return (a / gcd(a, b)) * b;
  endfunction

  // dly = WAIT cycle (1-based) on which the coprocessor answers; outside 1..TMO means never
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic ie, input int dly, input logic poke, input logic clr_after);
    int s0;
    logic [31:0] ans, r;
    logic c;
    logic byp;
    byp = (a == 16'd0) || (b == 16'd0);
    wr(2'd0, {a, b});
    m_operands = {a, b};
    rd(2'd0, r); chk("opr_rb", r, m_operands);
    ans = op ? lcm(a, b) : gcd(a, b);
    s0 = starts;
    c = 1'($urandom_range(0, 1));
    wr(2'd1, {28'd0, c, ie, op, 1'b1});
    m_irq_en = ie; m_op = op; m_done = 1'b0; m_tmo = 1'b0;
    if (byp) begin
      m_result = op ? 32'd0 : {16'd0, a | b};
      m_done = 1'b1;
      chk("byp_start", cop_start, 0);
    end else begin
      chk("launch_start", cop_start, 1);
      chk("launch_opnd", cop_operand, m_operands);
      chk("launch_op", cop_op, op);
      rd(2'd2, r); chk("busy_stat", r, {28'd0, op, 2'b00, 1'b1});
      tick();
      for (int w = 1; w <= TMO + 2; w++) begin
        chk("wait_start", cop_start, 0);
        chk("wait_opnd", cop_operand, m_operands);
        if (poke && w == 1) begin
          cpu_we = 1'b1; cpu_addr = 2'd0; cpu_wdata = 32'h0001_0001;
        end else if (poke && w == 2) begin
          cpu_we = 1'b1; cpu_addr = 2'd1; cpu_wdata = {29'd0, ie, ~op, 1'b1};
        end
        if (w == dly) begin
          cop_done = 1'b1; cop_result = ans; m_result = ans; m_done = 1'b1;
        end else if (w == TMO) begin
          m_result = 32'hFFFF_FFFF; m_tmo = 1'b1;
        end
        tick();
        cpu_we = 1'b0; cop_done = 1'b0; cop_result = $urandom;
        if (m_done || m_tmo) break;
      end
    end
    rd(2'd2, r); chk("stat", r, {28'd0, m_op, m_tmo, m_done, 1'b0});
    rd(2'd3, r); chk("result", r, m_result);
    chk("irq", irq, m_irq_en & (m_done | m_tmo));
    rd(2'd1, r); chk("ctrl_rb", r, {29'd0, m_irq_en, m_op, 1'b0});
    rd(2'd0, r); chk("opr_hold", r, m_operands);
    cop_done = 1'b1; cop_result = 32'hDEAD_BEEF;
    tick();
    cop_done = 1'b0;
    wr(2'd2, $urandom);
    wr(2'd3, $urandom);
    rd(2'd3, r); chk("result_hold", r, m_result);
    rd(2'd2, r); chk("stat_hold", r, {28'd0, m_op, m_tmo, m_done, 1'b0});
    chk("starts", 32'(starts - s0), byp ? 32'd0 : 32'd1);
    if (clr_after) begin
      wr(2'd1, {28'd0, 1'b1, ie, 2'b00});
      m_done = 1'b0; m_tmo = 1'b0;
      rd(2'd2, r); chk("clr_stat", r, {28'd0, m_op, 3'b000});
      chk("clr_irq", irq, 0);
      rd(2'd3, r); chk("clr_result", r, m_result);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] a, b;
    reset = 1'b1; cpu_we = 1'b0; cpu_addr = 2'd0; cpu_wdata = 32'd0;
    cop_done = 1'b0; cop_result = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_start", cop_start, 0);
    chk("rst_opnd", cop_operand, 0);
    chk("rst_op", cop_op, 0);
    chk("rst_irq", irq, 0);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), r); chk("rst_reg", r, 0);
    end

    run_op(16'd12, 16'd18, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    run_op(16'd4,  16'd6,  1'b1, 1'b1, 3, 1'b0, 1'b1);
    run_op(16'd0,  16'd7,  1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'd0,  16'd7,  1'b1, 1'b1, 0, 1'b0, 1'b1);
    run_op(16'd3,  16'd5,  1'b0, 1'b1, 0, 1'b0, 1'b1);
    run_op(16'd9,  16'd6,  1'b1, 1'b0, TMO, 1'b0, 1'b0);
    run_op(16'd5,  16'd10, 1'b0, 1'b0, 4, 1'b1, 1'b0);
    run_op(16'd21, 16'd0,  1'b0, 1'b1, 2, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      run_op(a, b, 1'($urandom), 1'($urandom), $urandom_range(0, TMO + 1),
             1'($urandom), 1'($urandom));
    end

    wr(2'd0, {16'd21, 16'd14});
    wr(2'd1, 32'h0000_0007);
    chk("mid_launch", cop_start, 1);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cop_done = 1'b1; cop_result = 32'd7;
    tick();
    cop_done = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), r); chk("midrst_reg", r, 0);
    end
    chk("midrst_start", cop_start, 0);
    chk("midrst_opnd", cop_operand, 0);
    chk("midrst_op", cop_op, 0);
    chk("midrst_irq", irq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
